// File: rtl/rat_io_pkg.sv
// rat_io_pkg: shared constants for the RAT MCU port-mapped I/O controller.
//   Port IDs for the IN/OUT decode, button count and debounce defaults.
package rat_io_pkg;
  // Read ports
  localparam logic [7:0] SW_ID       = 8'h20;
  localparam logic [7:0] BTN_ID      = 8'h21;
  localparam logic [7:0] IRQ_STAT_ID = 8'h22;
  // Write ports
  localparam logic [7:0] LED_ID      = 8'h40;
  localparam logic [7:0] SSEG_ID     = 8'h81;
  localparam logic [7:0] IRQ_ACK_ID  = 8'hF0;
  // Read/write
  localparam logic [7:0] IRQ_MASK_ID = 8'hF1;

  localparam int NUM_BTN       = 4;
  localparam int DB_CYCLES_DEF = 500000;
  localparam int DB_W_DEF      = 20;   // 2**DB_W must exceed DB_CYCLES
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one-bit button conditioner.
//   CLK, RESET_N : clock, async active-low reset
//   RAW          : asynchronous bouncing input
//   STABLE       : debounced level
//   RISE         : 1-cycle pulse on the edge where STABLE goes 0->1
// A change is accepted only after the synchronized input has differed from
// STABLE for DB_CYCLES consecutive cycles; any agreement restarts the count.
module btn_debounce
  import rat_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic RAW,
  output logic STABLE,
  output logic RISE
);
  logic [1:0]      r_sync;
  logic            r_stable;
  logic [DB_W-1:0] r_cnt;
  logic            w_diff;
  logic            w_done;

  assign w_diff = r_sync[1] ^ r_stable;
  assign w_done = w_diff && (r_cnt == DB_W'(DB_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[0], RAW};
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign STABLE = r_stable;
  // Pulse coincides with the edge that loads STABLE=1, so the parent's
  // pending bit and the BTN read change on the same clock.
  assign RISE   = w_done & r_sync[1];
endmodule

// File: rtl/rat_io_ctrl.sv
// rat_io_ctrl: port-mapped I/O controller for the RAT MCU.
//   CLK, RESET_N        : clock, async active-low reset
//   IO_STRB/PORT_ID/OUT_PORT : MCU OUT bus (write on strobe)
//   IN_PORT             : combinational read data for the MCU IN instruction
//   INTR                : registered level interrupt, |(pending & mask)
//   SWITCHES, BTN       : asynchronous board inputs
//   LEDS, SSEG_VAL      : output registers
module rat_io_ctrl
  import rat_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         IO_STRB,
  input  logic [7:0]   PORT_ID,
  input  logic [7:0]   OUT_PORT,
  output logic [7:0]   IN_PORT,
  output logic         INTR,
  input  logic [7:0]   SWITCHES,
  input  logic [NUM_BTN-1:0] BTN,
  output logic [7:0]   LEDS,
  output logic [7:0]   SSEG_VAL
);
  logic [7:0]         r_leds;
  logic [7:0]         r_sseg;
  logic [NUM_BTN-1:0] r_mask;
  logic [NUM_BTN-1:0] r_pend;
  logic               r_intr;
  logic [1:0][7:0]    r_sw_sync;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_ack;

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .RAW    (BTN[g]),
        .STABLE (w_stable[g]),
        .RISE   (w_rise[g])
      );
    end
  endgenerate

  assign w_ack = (IO_STRB && PORT_ID == IRQ_ACK_ID) ? OUT_PORT[NUM_BTN-1:0] : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_leds    <= 8'h00;
      r_sseg    <= 8'h00;
      r_mask    <= '1;
      r_pend    <= '0;
      r_intr    <= 1'b0;
      r_sw_sync <= '0;
    end else begin
      r_sw_sync <= {r_sw_sync[0], SWITCHES};
      if (IO_STRB) begin
        case (PORT_ID)
          LED_ID:      r_leds <= OUT_PORT;
          SSEG_ID:     r_sseg <= OUT_PORT;
          IRQ_MASK_ID: r_mask <= OUT_PORT[NUM_BTN-1:0];
          default: ;
        endcase
      end
      // Set is ORed after the clear so a same-cycle edge survives an ack.
      r_pend <= (r_pend & ~w_ack) | w_rise;
      r_intr <= |(r_pend & r_mask);
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      SW_ID:       IN_PORT = r_sw_sync[1];
      BTN_ID:      IN_PORT = {4'b0, w_stable};
      IRQ_STAT_ID: IN_PORT = {4'b0, r_pend};
      IRQ_MASK_ID: IN_PORT = {4'b0, r_mask};
      default:     IN_PORT = 8'h00;
    endcase
  end

  assign LEDS     = r_leds;
  assign SSEG_VAL = r_sseg;
  assign INTR     = r_intr;
endmodule

// File: tb/tb_rat_io_ctrl.sv
module tb_rat_io_ctrl;
  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       IO_STRB;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic [7:0] IN_PORT;
  logic       INTR;
  logic [7:0] SWITCHES;
  logic [3:0] BTN;
  logic [7:0] LEDS;
  logic [7:0] SSEG_VAL;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] rdv;

  rat_io_ctrl #(.DB_CYCLES(8), .DB_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IO_STRB(IO_STRB), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .IN_PORT(IN_PORT), .INTR(INTR), .SWITCHES(SWITCHES),
    .BTN(BTN), .LEDS(LEDS), .SSEG_VAL(SSEG_VAL)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] d);
    PORT_ID = id;
    #1;
    d = IN_PORT;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    SWITCHES = 8'h00; BTN = 4'h0;
    tick(2);
    chk("rst_leds", LEDS, 8'h00);
    chk("rst_sseg", SSEG_VAL, 8'h00);
    chk("rst_intr", {7'b0, INTR}, 8'h00);
    rd(8'hF1, rdv); chk("rst_mask", rdv, 8'h0F);
    rd(8'h22, rdv); chk("rst_pend", rdv, 8'h00);
    RESET_N = 1'b1;
    tick();

    // Basic writes
    wr(8'h40, 8'hA5);
    chk("led_wr", LEDS, 8'hA5);
    chk("led_wr_sseg", SSEG_VAL, 8'h00);
    chk("led_wr_intr", {7'b0, INTR}, 8'h00);
    wr(8'h55, 8'hFF);
    chk("unmapped_led", LEDS, 8'hA5);
    chk("unmapped_sseg", SSEG_VAL, 8'h00);
    wr(8'h81, 8'h5A);
    chk("sseg_wr", SSEG_VAL, 8'h5A);

    // Switch synchronizer latency
    PORT_ID = 8'h20; SWITCHES = 8'h3C;
    tick();
    chk("sw_1cyc", IN_PORT, 8'h00);
    tick();
    chk("sw_2cyc", IN_PORT, 8'h3C);
    rd(8'h33, rdv); chk("unmapped_rd", rdv, 8'h00);

    // Bounce rejection on BTN[1]: 3-cycle runs never reach 8
    PORT_ID = 8'h21;
    for (int s = 0; s < 10; s++) begin
      BTN = (s % 2 == 0) ? 4'h2 : 4'h0;
      for (int c = 0; c < 3; c++) begin
        tick();
        chk("bounce_hold", IN_PORT, 8'h00);
      end
    end
    BTN = 4'h2;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("db_early", IN_PORT, 8'h00);
    end
    tick();
    chk("db_accept", IN_PORT, 8'h02);

    // Interrupt flow
    rd(8'h22, rdv); chk("irq_stat", rdv, 8'h02);
    chk("intr_lag", {7'b0, INTR}, 8'h00);
    tick();
    chk("intr_set", {7'b0, INTR}, 8'h01);
    wr(8'hF0, 8'h02);
    rd(8'h22, rdv); chk("ack_pend", rdv, 8'h00);
    chk("ack_intr_lag", {7'b0, INTR}, 8'h01);
    tick();
    chk("ack_intr", {7'b0, INTR}, 8'h00);
    BTN = 4'h0;
    tick(12);
    rd(8'h22, rdv); chk("fall_no_pend", rdv, 8'h00);
    rd(8'h21, rdv); chk("fall_btn", rdv, 8'h00);

    // Mask: upper nibble ignored
    wr(8'hF1, 8'hF0);
    rd(8'hF1, rdv); chk("mask_zero", rdv, 8'h00);
    BTN = 4'h1;
    tick(10);
    rd(8'h22, rdv); chk("masked_pend", rdv, 8'h01);
    tick(2);
    chk("masked_intr", {7'b0, INTR}, 8'h00);
    wr(8'hF1, 8'h01);
    chk("unmask_lag", {7'b0, INTR}, 8'h00);
    tick();
    chk("unmask_intr", {7'b0, INTR}, 8'h01);

    // Collision: ack lands on the same edge as a new rise
    BTN = 4'h0;
    wr(8'hF0, 8'h01);
    tick(11);
    rd(8'h22, rdv); chk("pre_coll_pend", rdv, 8'h00);
    BTN = 4'h1;
    tick(9);
    rd(8'h22, rdv); chk("pre_coll_pend2", rdv, 8'h00);
    wr(8'hF0, 8'h01);
    rd(8'h22, rdv); chk("coll_set_wins", rdv, 8'h01);
    tick();
    chk("coll_intr", {7'b0, INTR}, 8'h01);

    // Async reset mid-debounce
    wr(8'hF1, 8'h0F);
    BTN = 4'h3;
    tick(10);
    rd(8'h22, rdv); chk("pend_3", rdv, 8'h03);
    BTN = 4'h7;
    tick(5);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_intr", {7'b0, INTR}, 8'h00);
    chk("arst_leds", LEDS, 8'h00);
    rd(8'h22, rdv); chk("arst_pend", rdv, 8'h00);
    BTN = 4'h0;
    #1;
    RESET_N = 1'b1;
    tick(20);
    chk("post_rst_intr", {7'b0, INTR}, 8'h00);
    rd(8'h22, rdv); chk("post_rst_pend", rdv, 8'h00);
    rd(8'h21, rdv); chk("post_rst_btn", rdv, 8'h00);
    rd(8'hF1, rdv); chk("post_rst_mask", rdv, 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rat_io_ctrl.md
Name: rat_io_ctrl

Overview:
- Port-mapped I/O controller directly downstream of the RAT MCU.
- Consumes the MCU's OUT instruction bus (IO_STRB, PORT_ID, OUT_PORT) and drives output registers.
- Returns IN_PORT data for IN instructions and generates the MCU's INTR line from debounced push-button edges.
- Sits between the MCU and board pins (switches, buttons, LEDs, seven-segment value).

Parameters:
- DB_CYCLES, 500000, stable-sample count required before a button change is accepted (bench uses 8).
- DB_W, 20, debounce counter width; must satisfy 2**DB_W > DB_CYCLES.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IO_STRB  in  1  MCU write strobe, 1-cycle pulse per OUT.
- PORT_ID  in  8  MCU port address (read and write).
- OUT_PORT  in  8  MCU write data.
- IN_PORT  out  8  read data returned to MCU.
- INTR  out  1  interrupt request to MCU, level, registered.
- SWITCHES  in  8  asynchronous board switches.
- BTN  in  4  asynchronous, bouncing board buttons, active-high.
- LEDS  out  8  LED register.
- SSEG_VAL  out  8  seven-segment display value register.

Behaviour:
Port map (constants in package):
- 0x20 SW: read.
- 0x21 BTN: read.
- 0x22 IRQ_STAT: read.
- 0x40 LED: write.
- 0x81 SSEG: write.
- 0xF0 IRQ_ACK: write, W1C.
- 0xF1 IRQ_MASK: read and write.

Reset (RESET_N=0, async):
- LEDS=0x00, SSEG_VAL=0x00, mask=0xF, pending=0x0, INTR=0.
- All synchronizer flops, stable button states and debounce counters are 0.

Writes:
- On the rising edge where IO_STRB=1, the register decoded from PORT_ID loads OUT_PORT.
- Outputs are visible 1 cycle later.
- Writes to unmapped IDs are ignored.
- IRQ_MASK loads OUT_PORT[3:0]; bits [7:4] are ignored.
- IRQ_ACK clears pending[i] for each OUT_PORT[i]=1 (i=0..3).

Reads:
- IN_PORT is a combinational mux on PORT_ID, independent of IO_STRB. The MCU samples it in the same cycle.
- SW: 2-flop synchronized SWITCHES.
- BTN: {4'b0, stable[3:0]}.
- IRQ_STAT: {4'b0, pending}.
- IRQ_MASK: {4'b0, mask}.
- Any other ID: 0x00.

Button path, per bit i:
- 2-flop synchronizer feeds the debouncer.
- If sync != stable: cnt increments. When cnt reaches DB_CYCLES-1, stable <= sync and cnt <= 0.
- If sync == stable: cnt <= 0, so a bounce restarts the count.
- A rising edge of stable (0->1) sets pending[i]. Falling edges set nothing.
- Latency from a clean BTN rise to pending set: 2 sync cycles + DB_CYCLES cycles.

Interrupt:
- INTR <= |(pending & mask), registered, so it follows pending/mask by 1 cycle.
- INTR stays high until software acks every unmasked pending bit.
- Masking a bit hides it from INTR but leaves it in pending.
- Simultaneous edge-set and ack of the same bit in one cycle: set wins, bit stays 1.
- Ack of a bit with no pending edge has no effect.

Boundary conditions:
- Reset asserted mid-debounce: counters and stable are cleared, and no edge is produced on release.
- Counter saturation cannot occur because the count wraps to 0 at DB_CYCLES-1.

Decomposition:
- Package rat_io_pkg holds:
  - port ID localparams (SW_ID, BTN_ID, IRQ_STAT_ID, LED_ID, SSEG_ID, IRQ_ACK_ID, IRQ_MASK_ID);
  - NUM_BTN=4;
  - the debounce default.
- Sub-module btn_debounce, instantiated once per button:
  - one bit: synchronizer, counter, stable register;
  - ports CLK, RESET_N, RAW, STABLE, RISE.
- rat_io_ctrl contains the register decode, read mux and IRQ logic.

Test Plan:
- Reset, then write: RESET_N=0 then 1; PORT_ID=0x40, OUT_PORT=0xA5, IO_STRB=1 for 1 cycle -> LEDS=0xA5 next cycle; SSEG_VAL=0x00; INTR=0.
- Unmapped write and switch read: IO_STRB pulse to 0x55 with 0xFF -> LEDS and SSEG_VAL unchanged. SWITCHES=0x3C, PORT_ID=0x20 -> IN_PORT=0x3C after 2 cycles; unmapped read returns 0x00.
- Bounce rejection (DB_CYCLES=8): BTN[1] toggles every 3 cycles for 30 cycles, then holds 1 -> BTN read goes 0x00 to 0x02 exactly 10 cycles after the final rise (2 sync + 8 debounce), with no earlier change.
- Interrupt flow: BTN[1] clean press -> pending=0x2, INTR=1 one cycle later, IRQ_STAT=0x02. Write 0xF0 with 0x02 -> pending=0, INTR=0 the following cycle.
- Mask and collision: mask=0x0 via 0xF1, press BTN[0] -> IRQ_STAT=0x01, INTR stays 0; set mask=0x1 -> INTR=1. Ack bit0 in the same cycle as a new BTN[0] debounced edge -> pending[0] stays 1.
- Async reset mid-operation: pending=0x3 and BTN[2] mid-debounce; pulse RESET_N low between clock edges -> INTR, LEDS and pending drop to 0 immediately. After release with BTN[2] still low, no interrupt is raised.
